// File: rtl/pma_multi_pkg.sv
// Shared EBOX definitions: memory cycle-type encodings and the PMA sequencer states.
// Pure type package, no logic and no latency.
// Imported by pma_multi and pma_rr_arb.
package pma_multi_pkg;

    typedef enum logic [2:0] {
        CYC_NONE   = 3'd0,
        CYC_EBOX   = 3'd1,
        CYC_REFILL = 3'd2,
        CYC_CHAN   = 3'd3,
        CYC_WB     = 3'd4,
        CYC_CCA    = 3'd5
    } cyc_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } pma_state_e;

endpackage

// File: rtl/pma_rr_arb.sv
// Round-robin pick among channel requestors, search starts one above the last granted channel.
// Combinational pick; the pointer moves on the edge a channel cycle is granted.
// No backpressure of its own: the caller decides when a pick is consumed via adv_i.
module pma_rr_arb
    import pma_multi_pkg::*;
#(
    parameter int NCHAN = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NCHAN-1:0] req_i,
    input  logic             adv_i,
    input  logic [2:0]       adv_idx_i,
    output logic             any_o,
    output logic [2:0]       idx_o
);

    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    int         c;

    always_comb begin
        ptr_d = (adv_idx_i == 3'(NCHAN - 1)) ? 3'd0 : adv_idx_i + 3'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q <= 3'd0;
        end else if (adv_i) begin
            ptr_q <= ptr_d;
        end
    end

    // ptr_q is always below NCHAN, so one subtraction is enough to wrap.
    always_comb begin
        any_o = 1'b0;
        idx_o = 3'd0;
        c     = 0;
        for (int k = 0; k < NCHAN; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NCHAN) c = c - NCHAN;
            if (!any_o && req_i[c]) begin
                any_o = 1'b1;
                idx_o = 3'(c);
            end
        end
    end

endmodule

// File: rtl/pma_multi.sv
// Physical memory address multiplexer: arbitrates EBOX/refill/channel/writeback/CCA cycles, holds pa until memory accepts.
// One edge from request to held pa; grant pulses the edge after ready_to_go in HOLD. Optional PMA_MULTI_PAR_EN adds pa parity.
// Requestors hold their request until their grant; memory stalls the held cycle by withholding ready_to_go.
module pma_multi
    import pma_multi_pkg::*;
#(
    parameter int PA_W  = 22,
    parameter int OFF_W = 9,
    parameter int NCHAN = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ebox_req,
    input  logic [PA_W-1:0]       ebox_va,
    input  logic                  ebox_paged,
    input  logic                  ebox_user,
    input  logic [PA_W-OFF_W-1:0] pt_page,
    input  logic                  refill_req,
    input  logic [NCHAN-1:0]      chan_req,
    input  logic [NCHAN*PA_W-1:0] chan_adr,
    input  logic                  wb_req,
    input  logic [PA_W-1:0]       wb_adr,
    input  logic                  cca_start,
    input  logic                  ubr_load,
    input  logic                  ebr_load,
    input  logic [PA_W-OFF_W-1:0] base_data,
    input  logic                  ready_to_go,
    input  logic                  era_hold,
    output logic [PA_W-1:0]       pa,
    output logic                  pa_par,
    output logic [2:0]            cyc_type,
    output logic [2:0]            cyc_chan,
    output logic                  busy,
    output logic                  ebox_gnt,
    output logic                  refill_gnt,
    output logic                  wb_gnt,
    output logic                  cca_gnt,
    output logic [NCHAN-1:0]      chan_gnt,
    output logic [PA_W-1:0]       era,
    output logic                  cca_busy,
    output logic                  cca_done
);

    localparam int PAGE_W = PA_W - OFF_W;

    pma_state_e        state_q;
    logic [PA_W-1:0]   pa_q, pa_d;
    cyc_type_e         cyc_type_q, type_d;
    logic [2:0]        cyc_chan_q, chan_d;
    logic              ebox_gnt_q, refill_gnt_q, wb_gnt_q, cca_gnt_q;
    logic [NCHAN-1:0]  chan_gnt_q;
    logic [PA_W-1:0]   era_q;
    logic [PAGE_W-1:0] ubr_q, ebr_q, cca_page_q;
    logic [OFF_W-1:0]  cca_cnt_q;
    logic              cca_busy_q, cca_done_q;

    logic              chan_any;
    logic [2:0]        chan_idx;
    logic              fire, any_req, grant_any;

    assign fire      = (state_q == ST_HOLD) && ready_to_go;
    assign grant_any = ebox_gnt_q | refill_gnt_q | wb_gnt_q | cca_gnt_q | (|chan_gnt_q);

    pma_rr_arb #(.NCHAN(NCHAN)) u_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_i     (chan_req),
        .adv_i     (fire && (cyc_type_q == CYC_CHAN)),
        .adv_idx_i (cyc_chan_q),
        .any_o     (chan_any),
        .idx_o     (chan_idx)
    );

    assign any_req = wb_req | refill_req | chan_any | cca_busy_q | ebox_req;

    always_comb begin
        pa_d   = ebox_va;
        type_d = CYC_NONE;
        chan_d = 3'd0;
        if (wb_req) begin
            pa_d   = wb_adr;
            type_d = CYC_WB;
        end else if (refill_req) begin
            pa_d   = {ebox_user ? ubr_q : ebr_q, ebox_va[PA_W-1 -: OFF_W]};
            type_d = CYC_REFILL;
        end else if (chan_any) begin
            pa_d   = chan_adr[int'(chan_idx)*PA_W +: PA_W];
            type_d = CYC_CHAN;
            chan_d = chan_idx;
        end else if (cca_busy_q) begin
            pa_d   = {cca_page_q, cca_cnt_q};
            type_d = CYC_CCA;
        end else if (ebox_req) begin
            pa_d   = ebox_paged ? {pt_page, ebox_va[OFF_W-1:0]} : ebox_va;
            type_d = CYC_EBOX;
        end
    end

    // Sequencer: winner is frozen in HOLD, so requests dropping mid-cycle cannot change it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pa_q         <= '0;
            cyc_type_q   <= CYC_NONE;
            cyc_chan_q   <= 3'd0;
            ebox_gnt_q   <= 1'b0;
            refill_gnt_q <= 1'b0;
            wb_gnt_q     <= 1'b0;
            cca_gnt_q    <= 1'b0;
            chan_gnt_q   <= '0;
            era_q        <= '0;
        end else begin
            ebox_gnt_q   <= 1'b0;
            refill_gnt_q <= 1'b0;
            wb_gnt_q     <= 1'b0;
            cca_gnt_q    <= 1'b0;
            chan_gnt_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q    <= ST_HOLD;
                        pa_q       <= pa_d;
                        cyc_type_q <= type_d;
                        cyc_chan_q <= chan_d;
                    end
                end
                ST_HOLD: begin
                    if (ready_to_go) begin
                        state_q      <= ST_IDLE;
                        cyc_type_q   <= CYC_NONE;
                        cyc_chan_q   <= 3'd0;
                        ebox_gnt_q   <= (cyc_type_q == CYC_EBOX);
                        refill_gnt_q <= (cyc_type_q == CYC_REFILL);
                        wb_gnt_q     <= (cyc_type_q == CYC_WB);
                        cca_gnt_q    <= (cyc_type_q == CYC_CCA);
                        chan_gnt_q   <= (cyc_type_q == CYC_CHAN) ? (NCHAN'(1) << cyc_chan_q) : '0;
                    end
                end
            endcase
            // pa_q still holds the granted address during the grant pulse.
            if (grant_any && !era_hold) era_q <= pa_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ubr_q <= '0;
            ebr_q <= '0;
        end else begin
            if (ubr_load) ubr_q <= base_data;
            if (ebr_load) ebr_q <= base_data;
        end
    end

    // Cache sweep walks the page from the top word down; a new start always wins.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cca_page_q <= '0;
            cca_cnt_q  <= '0;
            cca_busy_q <= 1'b0;
            cca_done_q <= 1'b0;
        end else begin
            cca_done_q <= 1'b0;
            if (cca_start) begin
                cca_page_q <= ebox_va[PA_W-1 -: PAGE_W];
                cca_cnt_q  <= '1;
                cca_busy_q <= 1'b1;
            end else if (fire && (cyc_type_q == CYC_CCA)) begin
                if (cca_cnt_q == '0) begin
                    cca_busy_q <= 1'b0;
                    cca_done_q <= 1'b1;
                end else begin
                    cca_cnt_q <= cca_cnt_q - OFF_W'(1);
                end
            end
        end
    end

`ifdef PMA_MULTI_PAR_EN
    assign pa_par = ~^pa_q;
`else
    assign pa_par = 1'b0;
`endif

    assign pa         = pa_q;
    assign cyc_type   = cyc_type_q;
    assign cyc_chan   = cyc_chan_q;
    assign busy       = (state_q == ST_HOLD);
    assign ebox_gnt   = ebox_gnt_q;
    assign refill_gnt = refill_gnt_q;
    assign wb_gnt     = wb_gnt_q;
    assign cca_gnt    = cca_gnt_q;
    assign chan_gnt   = chan_gnt_q;
    assign era        = era_q;
    assign cca_busy   = cca_busy_q;
    assign cca_done   = cca_done_q;

endmodule
